// File: rtl/s2p_word_sequencer.sv
// Packs a valid/ready byte stream into 64-bit words for the 8-lane byte splitter.
// Optional idle auto-flush is enabled by defining S2P_WORD_SEQUENCER_TIMEOUT_EN.
module s2p_word_sequencer #(
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [63:0] d_out,
  output logic        load,
  output logic        word_valid,
  input  logic        word_ack,
  output logic [3:0]  vld_bytes,
  output logic        timeout_flag
);

  // Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
  // in_ready is registered from next-state, so it is already low in the load cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] d_d;
  logic [3:0]  vld_d;
  logic        timeout_d;
  logic        accept;
  logic        expire;
  logic [5:0]  lane_lsb;

  assign accept   = in_valid && in_ready;
  assign lane_lsb = {vld_bytes[2:0], 3'b000};

`ifdef S2P_WORD_SEQUENCER_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Counts FILL cycles without an accept; cleared on entry and on every byte.
  always_ff @(posedge clk) begin
    if (!reset_n || state_q != FILL || state_d != FILL || accept) begin
      idle_cnt <= 16'd0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign expire = (state_q == FILL) && !accept && (idle_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    d_d       = d_out;
    vld_d     = vld_bytes;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FILL;
          d_d     = {{7{PAD_BYTE}}, in_byte};
          vld_d   = 4'd1;
        end
      end
      FILL: begin
        if (accept) begin
          d_d[lane_lsb +: 8] = in_byte;
          vld_d              = vld_bytes + 4'd1;
        end
        // Flush closes the word after any same-cycle byte has been written.
        if (flush || (accept && vld_bytes == 4'd7)) begin
          state_d = PRESENT;
        end else if (expire) begin
          state_d   = PRESENT;
          timeout_d = 1'b1;
        end
      end
      PRESENT: begin
        if (word_ack) begin
          state_d = IDLE;
          vld_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      d_out        <= 64'd0;
      vld_bytes    <= 4'd0;
      load         <= 1'b0;
      word_valid   <= 1'b0;
      in_ready     <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_out        <= d_d;
      vld_bytes    <= vld_d;
      load         <= (state_d == PRESENT) && (state_q != PRESENT);
      word_valid   <= (state_d == PRESENT);
      in_ready     <= (state_d != PRESENT);
      timeout_flag <= timeout_d;
    end
  end

endmodule

// File: tb/tb_s2p_word_sequencer.sv
// Bench for s2p_word_sequencer: directed scenarios then random traffic, checked
// every cycle against a byte-queue reference model and a word scoreboard.
module tb_s2p_word_sequencer;

  localparam logic [7:0] PAD = 8'hFF;
  localparam int         TO  = 4;
`ifdef S2P_WORD_SEQUENCER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [63:0] d_out;
  logic        load;
  logic        word_valid;
  logic        word_ack = 1'b0;
  logic [3:0]  vld_bytes;
  logic        timeout_flag;

  s2p_word_sequencer #(.PAD_BYTE(PAD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .d_out(d_out), .load(load),
    .word_valid(word_valid), .word_ack(word_ack), .vld_bytes(vld_bytes),
    .timeout_flag(timeout_flag)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: bytes of the word in progress plus the word held for the consumer
  logic [7:0]  cur_q[$];
  logic [63:0] exp_q[$];
  bit          holding, ready_e, load_e, tflag_e;
  int          held_cnt, idle, hold_cyc;
  logic [63:0] held_word, dout_e;

  function automatic logic [63:0] pack();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = (i < cur_q.size()) ? cur_q[i] : PAD;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] b, input bit f, input bit a, input bit r);
    int  was;
    bit  acc, by_flush, by_to;
    load_e  = 1'b0;
    tflag_e = 1'b0;
    if (!r) begin
      cur_q.delete();
      holding = 0; ready_e = 0; dout_e = '0; held_cnt = 0; idle = 0; hold_cyc = 0;
      return;
    end
    if (holding) begin
      hold_cyc++;
      if (a) holding = 0;
    end else begin
      was = cur_q.size();
      acc = v && ready_e;
      if (acc) begin
        cur_q.push_back(b);
        idle = 0;
      end else if (was > 0) begin
        idle++;
      end
      by_flush = f && (was > 0);
      by_to    = TO_EN && !acc && (was > 0) && (idle == TO);
      if (cur_q.size() > 0) dout_e = pack();
      if (cur_q.size() == 8 || by_flush || by_to) begin
        held_word = dout_e;
        held_cnt  = cur_q.size();
        holding   = 1;
        hold_cyc  = 0;
        load_e    = 1;
        tflag_e   = by_to && !by_flush;
        exp_q.push_back(dout_e);
        cur_q.delete();
        idle = 0;
      end
    end
    ready_e = !holding;
  endtask

  // driver: apply inputs, clock, advance model, sample on the falling edge
  task automatic cyc(input bit v, input logic [7:0] b, input bit f, input bit a, input bit r);
    logic [63:0] w;
    in_valid = v; in_byte = b; flush = f; word_ack = a; reset_n = r;
    @(posedge clk);
    model_edge(v, b, f, a, r);
    @(negedge clk);
    chk("in_ready", in_ready, ready_e);
    chk("load", load, load_e);
    chk("word_valid", word_valid, holding);
    chk("vld_bytes", vld_bytes, holding ? held_cnt : cur_q.size());
    chk("d_out", d_out, dout_e);
    chk("timeout_flag", timeout_flag, tflag_e);
    if (load === 1'b1) begin
      chk("sb_load_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("sb_word", d_out, w);
      end
    end
  endtask

  initial begin
    logic [7:0] nb;
    int nloads, ntflags, lvld;

    // reset and release
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("rst_dout", d_out, 64'd0);
    cyc(0, 8'h00, 0, 0, 1);
    chk("ready_after_rst", in_ready, 1);

    // full word 11..88, ack two cycles after load
    for (int i = 1; i <= 8; i++) cyc(1, 8'(8'h11 * i), 0, 0, 1);
    chk("w1_load", load, 1);
    chk("w1_word", d_out, 64'h8877665544332211);
    chk("w1_vld", vld_bytes, 4'd8);
    cyc(0, 8'h00, 0, 0, 1);
    chk("w1_noreload", load, 0);
    cyc(0, 8'h00, 0, 1, 1);
    chk("w1_ready_back", in_ready, 1);

    // partial word with flush
    cyc(1, 8'hA1, 0, 0, 1);
    cyc(1, 8'hA2, 0, 0, 1);
    cyc(1, 8'hA3, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    chk("flush_word", d_out, 64'hFFFFFFFFFFA3A2A1);
    chk("flush_vld", vld_bytes, 4'd3);
    cyc(0, 8'h00, 0, 1, 1);

    // flush coincident with third byte, then flush while idle
    cyc(1, 8'hC1, 0, 0, 1);
    cyc(1, 8'hC2, 0, 0, 1);
    cyc(1, 8'hC3, 1, 0, 1);
    chk("cflush_vld", vld_bytes, 4'd3);
    chk("cflush_lane2", d_out[23:16], 8'hC3);
    cyc(0, 8'h00, 0, 1, 1);
    cyc(0, 8'h00, 1, 0, 1);
    chk("idle_flush_noload", load, 0);
    cyc(0, 8'h00, 0, 0, 1);
    chk("idle_flush_novalid", word_valid, 0);

    // in_valid held through PRESENT, ack after 5 held cycles
    nb = 8'h30;
    repeat (30) begin
      logic [7:0] b;
      bit a;
      b = nb;
      a = holding && (hold_cyc == 5);
      if (ready_e) nb = nb + 8'd1;
      cyc(1, b, 0, a, 1);
    end
    cyc(0, 8'h00, 1, 0, 1);
    repeat (8) cyc(0, 8'h00, 0, holding && hold_cyc >= 1, 1);

    // reset mid-word, then a clean word
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0, 1);
    cyc(1, 8'h5F, 0, 0, 0);
    chk("midrst_load", load, 0);
    chk("midrst_vld", vld_bytes, 4'd0);
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h60 + i), 0, 0, 1);
    chk("postrst_word", d_out, 64'h6766656463626160);
    cyc(0, 8'h00, 0, 1, 1);

    // two bytes then idle: auto-flush only when the timeout is built in
    cyc(1, 8'hD1, 0, 0, 1);
    cyc(1, 8'hD2, 0, 0, 1);
    nloads = 0; ntflags = 0; lvld = 0;
    repeat (8) begin
      cyc(0, 8'h00, 0, 0, 1);
      if (load === 1'b1) begin nloads++; lvld = vld_bytes; end
      if (timeout_flag === 1'b1) ntflags++;
    end
    chk("to_loads", nloads, TO_EN ? 1 : 0);
    chk("to_flags", ntflags, TO_EN ? 1 : 0);
    chk("to_vld", lvld, TO_EN ? 2 : 0);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    cyc(0, 8'h00, 0, 1, 1);

    // randomized traffic
    repeat (600) begin
      bit v, f, a, r;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0);
      a = holding ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 99) != 0);
      cyc(v, 8'($urandom), f, a, r);
    end
    cyc(0, 8'h00, 1, 0, 1);
    repeat (4) cyc(0, 8'h00, 0, 1, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
